// File: rtl/pc_seq_unit.sv
// LC-3 program-counter unit: sequential/mux PC update plus vectored entry
// with an internal LIFO return stack for fast RTI.
module pc_seq_unit #(
  parameter int unsigned       WIDTH     = 16,
  parameter int unsigned       INC       = 1,
  parameter logic [WIDTH-1:0]  RESET_VEC = 16'h3000,
  parameter int unsigned       DEPTH     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ldPC,
  input  logic [1:0]       selPC,
  input  logic [WIDTH-1:0] eabOut,
  input  logic [WIDTH-1:0] Bus,
  input  logic             vecEn,
  input  logic [WIDTH-1:0] vecAddr,
  input  logic             retEn,
  output logic [WIDTH-1:0] PCOut,
  output logic [WIDTH-1:0] PCInc,
  output logic             stkEmpty,
  output logic             stkFull,
  output logic             stkErr
);

  localparam int unsigned      PW      = $clog2(DEPTH);
  localparam int unsigned      CW      = PW + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);

  logic [WIDTH-1:0] r_pc;
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic [WIDTH-1:0] r_stk [DEPTH];

  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pc_inc;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_err_nxt;
  logic             w_push;
  logic             w_empty;
  logic             w_full;
  logic [PW-1:0]    w_top;

  assign w_pc_inc = r_pc + INC_W;
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == DEPTH_C);
  assign w_top    = r_cnt[PW-1:0] - PW'(1);

  // Requests are strictly prioritised: return, then vector, then plain load.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_cnt_nxt = r_cnt;
    w_err_nxt = r_err;
    w_push    = 1'b0;
    if (retEn) begin
      if (w_empty) begin
        w_err_nxt = 1'b1;
      end else begin
        w_pc_nxt  = r_stk[w_top];
        w_cnt_nxt = r_cnt - CW'(1);
      end
    end else if (vecEn) begin
      w_pc_nxt = vecAddr;
      if (w_full) begin
        w_err_nxt = 1'b1;
      end else begin
        w_push    = 1'b1;
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end else if (ldPC) begin
      case (selPC)
        2'b00:   w_pc_nxt = w_pc_inc;
        2'b01:   w_pc_nxt = eabOut;
        2'b10:   w_pc_nxt = Bus;
        default: w_pc_nxt = r_pc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc  <= RESET_VEC;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  // Storage is deliberately unreset; the count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_stk[r_cnt[PW-1:0]] <= r_pc;
  end

  assign PCOut    = r_pc;
  assign PCInc    = w_pc_inc;
  assign stkEmpty = w_empty;
  assign stkFull  = w_full;
  assign stkErr   = r_err;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed vector table, hand-written
// stack-limit/reset sequences, and randomized traffic against a queue model.
module tb_pc_seq_unit;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ldPC, vecEn, retEn;
  logic [1:0]  selPC;
  logic [15:0] eabOut, Bus, vecAddr;
  logic [15:0] PCOut, PCInc;
  logic        stkEmpty, stkFull, stkErr;

  pc_seq_unit #(.WIDTH(16), .INC(1), .RESET_VEC(16'h3000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ldPC(ldPC), .selPC(selPC), .eabOut(eabOut),
    .Bus(Bus), .vecEn(vecEn), .vecAddr(vecAddr), .retEn(retEn),
    .PCOut(PCOut), .PCInc(PCInc), .stkEmpty(stkEmpty), .stkFull(stkFull),
    .stkErr(stkErr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: PC value, return stack as a queue, sticky error bit.
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  logic        m_err;

  typedef struct {
    logic        r, v, l;
    logic [1:0]  s;
    logic [15:0] e, b, va;
    logic [15:0] exp_pc;
    logic        exp_empty, exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, v, l, input logic [1:0] s,
                              input logic [15:0] e, b, va, pc,
                              input logic emp, err);
    vec_t t;
    t.r = r; t.v = v; t.l = l; t.s = s; t.e = e; t.b = b; t.va = va;
    t.exp_pc = pc; t.exp_empty = emp; t.exp_err = err;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_step(input logic r, v, l, input logic [1:0] s,
                            input logic [15:0] e, b, va);
    if (r) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else m_err = 1'b1;
    end else if (v) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(m_pc);
      else m_err = 1'b1;
      m_pc = va;
    end else if (l) begin
      case (s)
        2'd0: m_pc = 16'((32'(m_pc) + 1) % 65536);
        2'd1: m_pc = e;
        2'd2: m_pc = b;
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic r, v, l, input logic [1:0] s,
                     input logic [15:0] e, b, va);
    @(negedge clk);
    retEn = r; vecEn = v; ldPC = l; selPC = s; eabOut = e; Bus = b; vecAddr = va;
    @(posedge clk);
    model_step(r, v, l, s, e, b, va);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    retEn = 1'b0; vecEn = 1'b0; ldPC = 1'b0; selPC = 2'd0;
    m_pc = 16'h3000; m_stk.delete(); m_err = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_pc"},    PCOut, m_pc);
    chk({tag, "_inc"},   PCInc, m_pc + 16'd1);
    chk({tag, "_empty"}, {15'd0, stkEmpty}, {15'd0, m_stk.size() == 0});
    chk({tag, "_full"},  {15'd0, stkFull},  {15'd0, m_stk.size() == DEPTH});
    chk({tag, "_err"},   {15'd0, stkErr},   {15'd0, m_err});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    retEn = 1'b0; vecEn = 1'b0; ldPC = 1'b0; selPC = 2'd0;
    eabOut = '0; Bus = '0; vecAddr = '0;

    // r v l sel eab bus vaddr -> pc empty err
    tbl.push_back(mk(0,0,1,2'd0,16'h0,16'h0,16'h0,16'h3001,1,0));
    tbl.push_back(mk(0,0,1,2'd0,16'h0,16'h0,16'h0,16'h3002,1,0));
    tbl.push_back(mk(0,0,1,2'd0,16'h0,16'h0,16'h0,16'h3003,1,0));
    tbl.push_back(mk(0,0,1,2'd1,16'h4000,16'h1111,16'h0,16'h4000,1,0));
    tbl.push_back(mk(0,0,1,2'd2,16'h2222,16'h5123,16'h0,16'h5123,1,0));
    tbl.push_back(mk(0,0,1,2'd3,16'hAAAA,16'hBBBB,16'h0,16'h5123,1,0));
    tbl.push_back(mk(0,0,0,2'd1,16'hCCCC,16'hDDDD,16'hEEEE,16'h5123,1,0));
    tbl.push_back(mk(0,0,1,2'd1,16'h3010,16'h0,16'h0,16'h3010,1,0));
    tbl.push_back(mk(0,1,0,2'd0,16'h0,16'h0,16'h0200,16'h0200,0,0));
    tbl.push_back(mk(0,1,1,2'd1,16'h9999,16'h0,16'h0300,16'h0300,0,0));
    tbl.push_back(mk(1,0,0,2'd0,16'h0,16'h0,16'h0,16'h0200,0,0));
    tbl.push_back(mk(1,0,0,2'd0,16'h0,16'h0,16'h0,16'h3010,1,0));
    tbl.push_back(mk(0,0,1,2'd1,16'h3020,16'h0,16'h0,16'h3020,1,0));
    tbl.push_back(mk(0,1,0,2'd0,16'h0,16'h0,16'h0400,16'h0400,0,0));
    tbl.push_back(mk(1,1,1,2'd2,16'h0,16'h7777,16'h0500,16'h3020,1,0));
    tbl.push_back(mk(0,0,1,2'd2,16'h0,16'hFFFF,16'h0,16'hFFFF,1,0));
    tbl.push_back(mk(0,0,1,2'd0,16'h0,16'h0,16'h0,16'h0000,1,0));

    do_reset();
    #1;
    chk("rst_pc", PCOut, 16'h3000);
    chk("rst_empty", {15'd0, stkEmpty}, 16'd1);
    chk("rst_full", {15'd0, stkFull}, 16'd0);
    chk("rst_err", {15'd0, stkErr}, 16'd0);

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].s, tbl[i].e, tbl[i].b, tbl[i].va);
      chk($sformatf("tbl%0d_pc", i), PCOut, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_inc", i), PCInc, tbl[i].exp_pc + 16'd1);
      chk($sformatf("tbl%0d_empty", i), {15'd0, stkEmpty}, {15'd0, tbl[i].exp_empty});
      chk($sformatf("tbl%0d_err", i), {15'd0, stkErr}, {15'd0, tbl[i].exp_err});
    end

    // Stack limits: DEPTH+1 vectors, DEPTH pops, one extra pop.
    do_reset();
    cyc(0,0,1,2'd1,16'h3100,16'h0,16'h0);
    for (int i = 0; i <= DEPTH; i++) begin
      cyc(0,1,0,2'd0,16'h0,16'h0,16'h1000 + 16'(i));
      if (i == DEPTH - 1) begin
        chk("lim_full_at_depth", {15'd0, stkFull}, 16'd1);
        chk("lim_err_at_depth", {15'd0, stkErr}, 16'd0);
      end
    end
    chk("lim_ovf_pc", PCOut, 16'h1000 + 16'(DEPTH));
    chk("lim_ovf_full", {15'd0, stkFull}, 16'd1);
    chk("lim_ovf_err", {15'd0, stkErr}, 16'd1);
    for (int j = 0; j < DEPTH; j++) begin
      cyc(1,0,0,2'd0,16'h0,16'h0,16'h0);
      chk($sformatf("lim_pop%0d", j), PCOut,
          (j < DEPTH - 1) ? 16'h1000 + 16'(DEPTH - 2 - j) : 16'h3100);
    end
    chk("lim_empty", {15'd0, stkEmpty}, 16'd1);
    cyc(1,0,0,2'd0,16'h0,16'h0,16'h0);
    chk("lim_unf_pc", PCOut, 16'h3100);
    chk("lim_unf_err", {15'd0, stkErr}, 16'd1);
    cyc(0,0,1,2'd0,16'h0,16'h0,16'h0);
    chk("lim_sticky_pc", PCOut, 16'h3101);
    chk("lim_sticky_err", {15'd0, stkErr}, 16'd1);

    // Asynchronous reset mid-run with a load pending and the stack busy.
    cyc(0,1,0,2'd0,16'h0,16'h0,16'h0777);
    @(negedge clk);
    ldPC = 1'b1; selPC = 2'd2; Bus = 16'h4444;
    #2 reset = 1'b0;
    #1;
    chk("async_pc", PCOut, 16'h3000);
    chk("async_empty", {15'd0, stkEmpty}, 16'd1);
    chk("async_err", {15'd0, stkErr}, 16'd0);
    do_reset();

    // Randomized traffic against the model, with periodic resets.
    for (int k = 0; k < 600; k++) begin
      logic r, v, l;
      logic [1:0] s;
      logic [15:0] e, b, va;
      if (k % 150 == 149) do_reset();
      r  = ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 2) == 0);
      l  = ($urandom_range(0, 1) == 1);
      s  = 2'($urandom_range(0, 3));
      e  = 16'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      va = 16'($urandom);
      cyc(r, v, l, s, e, b, va);
      chk_model($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
